// File: rtl/alu_exec_unit_if.sv
// Execute-stage bus between control FSM and ALU.
// Carries issue fields, status and register-file write-back.
interface alu_exec_unit_if #(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  start;
  logic                  flush;
  logic [3:0]            alu_op;
  logic [WIDTH-1:0]      op_a;
  logic [WIDTH-1:0]      op_b;
  logic [REG_ADDR_W-1:0] dest_reg;
  logic                  dest_wen;
  logic                  busy;
  logic                  done;
  logic [WIDTH-1:0]      result;
  logic                  zero;
  logic                  carry;
  logic                  overflow;
  logic                  illegal_op;
  logic [REG_ADDR_W-1:0] wb_reg;
  logic [WIDTH-1:0]      wb_data;
  logic                  wb_en;

  modport master (
    output start, flush, alu_op,
    output op_a, op_b,
    output dest_reg, dest_wen,
    input  busy, done, result,
    input  zero, carry, overflow,
    input  illegal_op,
    input  wb_reg, wb_data, wb_en
  );

  modport slave (
    input  start, flush, alu_op,
    input  op_a, op_b,
    input  dest_reg, dest_wen,
    output busy, done, result,
    output zero, carry, overflow,
    output illegal_op,
    output wb_reg, wb_data, wb_en
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Multi-cycle ALU execute stage with iterative multiply.
// Start/done handshake, registered result/flags, RF write-back.
module alu_exec_unit #(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 5,
  parameter int SHAMT_W    = 5
) (
  input logic          clk,
  input logic          rst_n,
  alu_exec_unit_if.slave bus
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_MULT,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0]      a_q, b_q, acc_q;
  logic [3:0]            op_q;
  logic [REG_ADDR_W-1:0] reg_q;
  logic                  wen_q;
  logic [SHAMT_W-1:0]    cnt_q;
  logic                  last_q;

  logic [WIDTH-1:0]      res_q;
  logic                  z_q, c_q, v_q, ill_q;
  logic [REG_ADDR_W-1:0] wb_reg_q;

  logic                  accept;
  logic                  commit;
  logic [WIDTH-1:0]      alu_res;
  logic                  alu_c, alu_v, alu_ill;
  logic [WIDTH-1:0]      res_d;
  logic [WIDTH:0]        sum, diff;
  logic [SHAMT_W-1:0]    shamt;
  logic                  sa, sb;

  assign accept = (state_q == S_IDLE)
                & bus.start & ~bus.flush;
  // The extra MULT cycle after the last step commits
  // the product exactly like EXEC commits an ALU result.
  assign commit = ~bus.flush
                & ((state_q == S_EXEC)
                 | ((state_q == S_MULT) & last_q));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; flush wins over everything
  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.start)
            state_d = (bus.alu_op == OP_MUL)
                    ? S_MULT : S_EXEC;
        end
        S_EXEC: state_d = S_DONE;
        S_MULT: if (last_q) state_d = S_DONE;
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign sum   = {1'b0, a_q} + {1'b0, b_q};
  assign diff  = {1'b0, a_q} - {1'b0, b_q};
  assign shamt = b_q[SHAMT_W-1:0];
  assign sa    = a_q[WIDTH-1];
  assign sb    = b_q[WIDTH-1];

  // Single-cycle ALU on latched operands
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_ill = 1'b0;
    unique case (op_q)
      OP_ADD: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (sa == sb)
                & (sum[WIDTH-1] != sa);
      end
      OP_SUB: begin
        alu_res = diff[WIDTH-1:0];
        alu_c   = diff[WIDTH];
        alu_v   = (sa != sb)
                & (diff[WIDTH-1] != sa);
      end
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_XOR: alu_res = a_q ^ b_q;
      OP_SLL: alu_res = a_q << shamt;
      OP_SRL: alu_res = a_q >> shamt;
      OP_SRA: alu_res =
        $unsigned($signed(a_q) >>> shamt);
      OP_SLT: alu_res[0] =
        $signed(a_q) < $signed(b_q);
      OP_SLTU: alu_res[0] = a_q < b_q;
      OP_MUL: alu_res = acc_q;
      default: alu_ill = 1'b1;
    endcase
  end

  assign res_d = alu_res;

  // Operand latch and shift-add multiply datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      op_q   <= '0;
      reg_q  <= '0;
      wen_q  <= 1'b0;
      cnt_q  <= '0;
      last_q <= 1'b0;
    end else if (accept) begin
      a_q    <= bus.op_a;
      b_q    <= bus.op_b;
      acc_q  <= '0;
      op_q   <= bus.alu_op;
      reg_q  <= bus.dest_reg;
      wen_q  <= bus.dest_wen;
      cnt_q  <= SHAMT_W'(WIDTH - 1);
      last_q <= 1'b0;
    end else if (state_q == S_MULT
                 && !last_q && !bus.flush) begin
      if (b_q[0]) acc_q <= acc_q + a_q;
      a_q <= a_q << 1;
      b_q <= b_q >> 1;
      if (cnt_q == '0) last_q <= 1'b1;
      else             cnt_q  <= cnt_q - 1'b1;
    end
  end

  // Result, flags and wb_reg held until next completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q    <= '0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
      ill_q    <= 1'b0;
      wb_reg_q <= '0;
    end else if (commit) begin
      res_q    <= res_d;
      z_q      <= (res_d == '0);
      c_q      <= alu_c;
      v_q      <= alu_v;
      ill_q    <= alu_ill;
      wb_reg_q <= reg_q;
    end
  end

  assign bus.busy       = (state_q != S_IDLE);
  assign bus.done       = (state_q == S_DONE);
  assign bus.result     = res_q;
  assign bus.wb_data    = res_q;
  assign bus.wb_reg     = wb_reg_q;
  assign bus.zero       = z_q;
  assign bus.carry      = c_q;
  assign bus.overflow   = v_q;
  assign bus.illegal_op = ill_q;
  assign bus.wb_en      = (state_q == S_DONE)
                        & wen_q
                        & (reg_q != '0)
                        & ~ill_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit.
// Directed vectors; monitor checks each done pulse.
module tb_alu_exec_unit;

  localparam int W  = 32;
  localparam int RW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_exec_unit_if #(.WIDTH(W), .REG_ADDR_W(RW)) bus();

  alu_exec_unit #(
    .WIDTH(W), .REG_ADDR_W(RW), .SHAMT_W(5)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct packed {
    logic [31:0] res;
    logic        z;
    logic        c;
    logic        v;
    logic        ill;
    logic        wb;
    logic [4:0]  rg;
    logic [31:0] cyc;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, req);
    end
  endtask

  // Monitor: every done pulse pops and compares one entry
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.done) begin
      if (sbq.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = sbq.pop_front();
        chk("result", bus.result, e.res);
        chk("wb_data", bus.wb_data, e.res);
        chk("zero", bus.zero, e.z);
        chk("carry", bus.carry, e.c);
        chk("overflow", bus.overflow, e.v);
        chk("illegal_op", bus.illegal_op, e.ill);
        chk("wb_en", bus.wb_en, e.wb);
        chk("wb_reg", bus.wb_reg, e.rg);
        chk("latency", cyc, e.cyc);
      end
    end
  end

  task automatic send(input logic [3:0] op,
                      input logic [31:0] a,
                      input logic [31:0] b,
                      input logic [4:0] rg,
                      input logic wen,
                      output logic [31:0] k);
    @(negedge clk);
    k = cyc;
    bus.start    = 1'b1;
    bus.alu_op   = op;
    bus.op_a     = a;
    bus.op_b     = b;
    bus.dest_reg = rg;
    bus.dest_wen = wen;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.op_a     = 32'hDEAD_BEEF;
    bus.op_b     = 32'hCAFE_F00D;
    bus.alu_op   = 4'd3;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((bus.busy || sbq.size() != 0)
           && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL timeout waiting for done");
    end
    @(negedge clk);
  endtask

  task automatic run(input logic [3:0] op,
                     input logic [31:0] a,
                     input logic [31:0] b,
                     input logic [4:0] rg,
                     input logic wen,
                     input logic [31:0] res,
                     input logic z, c, v, ill, wb,
                     input logic [31:0] lat);
    exp_t e;
    logic [31:0] k;
    send(op, a, b, rg, wen, k);
    e.res = res; e.z = z; e.c = c; e.v = v;
    e.ill = ill; e.wb = wb; e.rg = rg;
    e.cyc = k + lat;
    sbq.push_back(e);
    wait_idle();
  endtask

  initial begin
    exp_t        e;
    logic [31:0] k;
    int          bc;
    int          n;

    bus.start    = 1'b0;
    bus.flush    = 1'b0;
    bus.alu_op   = '0;
    bus.op_a     = '0;
    bus.op_b     = '0;
    bus.dest_reg = '0;
    bus.dest_wen = 1'b0;

    #12;
    chk("reset_outputs",
        {bus.busy, bus.done, bus.wb_en, bus.zero,
         bus.carry, bus.overflow, bus.illegal_op,
         bus.wb_reg, bus.result, bus.wb_data}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // op a b rd wen | res z c v ill wb lat
    run(0, 32'h7FFFFFFF, 32'h1, 3, 1,
        32'h80000000, 0, 0, 1, 0, 1, 2);
    run(1, 32'h5, 32'h7, 0, 1,
        32'hFFFFFFFE, 0, 1, 0, 0, 0, 2);
    run(7, 32'h80000000, 32'd31, 5, 1,
        32'hFFFFFFFF, 0, 0, 0, 0, 1, 2);
    run(8, 32'hFFFFFFFF, 32'h1, 6, 1,
        32'h1, 0, 0, 0, 0, 1, 2);
    run(9, 32'hFFFFFFFF, 32'h1, 6, 1,
        32'h0, 1, 0, 0, 0, 1, 2);
    run(2, 32'hF0F0F0F0, 32'h0FF00FF0, 7, 0,
        32'h00F000F0, 0, 0, 0, 0, 0, 2);
    run(3, 32'h12340000, 32'h00005678, 8, 1,
        32'h12345678, 0, 0, 0, 0, 1, 2);
    run(4, 32'hFFFFFFFF, 32'h0F0F0F0F, 9, 1,
        32'hF0F0F0F0, 0, 0, 0, 0, 1, 2);
    run(5, 32'h1, 32'd31, 1, 1,
        32'h80000000, 0, 0, 0, 0, 1, 2);
    run(5, 32'h1, 32'h21, 1, 1,
        32'h2, 0, 0, 0, 0, 1, 2);
    run(6, 32'h80000000, 32'd31, 2, 1,
        32'h1, 0, 0, 0, 0, 1, 2);
    run(0, 32'hFFFFFFFF, 32'h1, 11, 1,
        32'h0, 1, 1, 0, 0, 1, 2);
    run(1, 32'h80000000, 32'h1, 12, 1,
        32'h7FFFFFFF, 0, 0, 1, 0, 1, 2);

    // MUL with an ignored start pulse mid-operation
    send(4'd10, 32'h00010003, 32'h100, 10, 1, k);
    e.res = 32'h01000300; e.z = 0; e.c = 0;
    e.v = 0; e.ill = 0; e.wb = 1; e.rg = 10;
    e.cyc = k + 34;
    sbq.push_back(e);
    bc = 0;
    n  = 0;
    while (bus.busy && n < 60) begin
      bc++;
      if (n == 5) begin
        bus.start    = 1'b1;
        bus.alu_op   = 4'd0;
        bus.op_a     = 32'h1;
        bus.op_b     = 32'h1;
        bus.dest_reg = 5'd1;
        bus.dest_wen = 1'b1;
      end
      if (n == 6) bus.start = 1'b0;
      @(negedge clk);
      n++;
    end
    chk("mul_busy_cycles", bc, 34);
    wait_idle();

    // Flush a MUL at start+10
    send(4'd10, 32'h3, 32'h5, 10, 1, k);
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush_busy", bus.busy, 0);
    chk("flush_wb_en", bus.wb_en, 0);
    chk("flush_result_held", bus.result,
        32'h01000300);
    repeat (40) @(negedge clk);
    chk("flush_result_later", bus.result,
        32'h01000300);

    // Flush beats start in the same cycle
    bus.start  = 1'b1;
    bus.flush  = 1'b1;
    bus.alu_op = 4'd0;
    @(negedge clk);
    bus.start = 1'b0;
    bus.flush = 1'b0;
    chk("flush_over_start", bus.busy, 0);
    repeat (4) @(negedge clk);

    run(0, 32'h2, 32'h2, 4, 1,
        32'h4, 0, 0, 0, 0, 1, 2);
    run(13, 32'h1234, 32'h5678, 7, 1,
        32'h0, 1, 0, 0, 1, 0, 2);

    // Async reset in the middle of EXEC
    send(4'd0, 32'h5, 32'h6, 9, 1, k);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_outputs",
        {bus.busy, bus.done, bus.wb_en, bus.zero,
         bus.carry, bus.overflow, bus.illegal_op,
         bus.wb_reg, bus.result, bus.wb_data}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run(0, 32'h10, 32'h20, 15, 1,
        32'h30, 0, 0, 0, 0, 1, 2);

    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL pending_expected left=%0d",
               sbq.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
